mem_copy_engine: RTL and testbench



---
 rtl/mem_copy_engine.sv | 140 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus initiator that copies a block of words inside a single-port memory.
//
// Each word costs two cycles: a READ cycle that latches the combinational memory output,
// then a WRITE cycle that stores it at the destination. Words are moved in strict ascending
// order, so overlapping blocks with dst ahead of src replicate the leading words.
// A running 32-bit sum of the copied words is kept and held until the next accepted start.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          one-cycle request, sampled only while idle
//   src, dst, len  block descriptor, captured when start is accepted
//   busy           high while reading or writing
//   done           one-cycle completion pulse
//   sum            modular sum of the words copied by the last transfer
//   mem_a, mem_d   memory address / write data
//   mem_we         memory write enable
//   mem_spo        memory combinational read data
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              last_word;

  // idx is LEN_W wide so it can be compared against a full-depth len of 2**ADDR_W.
  assign last_word = (idx_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rd_buf_d = rd_buf_q;
    sum_d    = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sum_d = '0;
          if (len != '0) begin
            src_d   = src;
            dst_d   = dst;
            len_d   = len;
            idx_d   = '0;
            state_d = StRead;
          end else begin
            // Empty copy: report completion without touching memory.
            state_d = StDone;
          end
        end
      end
      StRead: begin
        rd_buf_d = mem_spo;
        sum_d    = sum_q + mem_spo;
        state_d  = StWrite;
      end
      StWrite: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      rd_buf_q <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rd_buf_q <= rd_buf_d;
      sum_q    <= sum_d;
    end
  end

  // Outputs depend on registered state only, so reset silences the bus immediately.
  always_comb begin
    busy   = (state_q == StRead) || (state_q == StWrite);
    done   = (state_q == StDone);
    sum    = sum_q;
    mem_a  = '0;
    mem_d  = '0;
    mem_we = 1'b0;
    unique case (state_q)
      StRead: begin
        mem_a = src_q + idx_q[ADDR_W-1:0];
      end
      StWrite: begin
        mem_a  = dst_q + idx_q[ADDR_W-1:0];
        mem_d  = rd_buf_q;
        mem_we = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a behavioural memory, a reference copy model that
// queues the expected read addresses and writes, and a per-cycle monitor that pops them.
module tb_mem_copy_engine;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  src;
  logic [4:0]  dst;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic [4:0]  mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_spo;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        poke_en;
  logic [4:0]  poke_a;
  logic [31:0] poke_d;

  logic [4:0]  exp_rd[$];
  wr_t         exp_wr[$];
  int          checks;
  int          errors;
  int          done_cnt;

  mem_copy_engine #(
    .ADDR_W(5),
    .DATA_W(32),
    .LEN_W (6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .mem_a  (mem_a),
    .mem_d  (mem_d),
    .mem_we (mem_we),
    .mem_spo(mem_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_spo = mem[mem_a];

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (mem_we) mem[mem_a] <= mem_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check any bus activity against the queues.
  task automatic tick();
    wr_t        w;
    logic [4:0] ra;
    @(negedge clk);
    if (done) done_cnt++;
    if (mem_we) begin
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(mem_a), 32'(w.a));
        check("wr_data", mem_d, w.d);
      end
    end else if (busy) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) begin
        ra = exp_rd.pop_front();
        check("rd_addr", 32'(mem_a), 32'(ra));
      end
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    ref_mem[a] = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic model_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                            output logic [31:0] esum);
    esum = '0;
    for (int i = 0; i < int'(l); i++) begin
      logic [4:0]  ra;
      logic [4:0]  wa;
      logic [31:0] v;
      ra = s + 5'(i);
      wa = d + 5'(i);
      v  = ref_mem[ra];
      ref_mem[wa] = v;
      esum += v;
      exp_rd.push_back(ra);
      exp_wr.push_back('{a: wa, d: v});
    end
  endtask

  // Called right after a falling edge with the engine idle.
  task automatic run_xfer(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                          input bit hold);
    logic [31:0] esum;
    int          dc0;
    model_copy(s, d, l, esum);
    dc0   = done_cnt;
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = l;
    tick();
    if (!hold) start = 1'b0;
    src = s + 5'd3;
    dst = d + 5'd9;
    len = l + 6'd1;
    for (int c = 0; c < 2 * int'(l); c++) begin
      check("busy_hi", 32'(busy), 32'd1);
      check("done_lo", 32'(done), 32'd0);
      if (hold && c == 1) start = 1'b0;
      if (hold && c == 2) start = 1'b1;
      tick();
    end
    check("busy_lo", 32'(busy), 32'd0);
    check("done_hi", 32'(done), 32'd1);
    check("sum", sum, esum);
    start = 1'b0;
    tick();
    check("done_once", 32'(done), 32'd0);
    check("sum_hold", sum, esum);
    check("done_count", 32'(done_cnt - dc0), 32'd1);
    check("rd_q_empty", 32'(exp_rd.size()), 32'd0);
    check("wr_q_empty", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_mem_a"}, 32'(mem_a), 32'd0);
    check({tag, "_mem_d"}, mem_d, 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    int dc0;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    start    = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    poke_en  = 1'b0;
    poke_a   = '0;
    poke_d   = '0;
    rst_n    = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_quiet("reset");
    for (int i = 0; i < 32; i++) begin
      poke(5'(i), (i == 0 || i == 1) ? 32'd3 : ((i == 20) ? 32'd20 : 32'd0));
    end
    rst_n = 1'b1;
    tick();

    // Basic copy, then a wrapping copy, then an empty copy.
    run_xfer(5'd0, 5'd10, 6'd2, 1'b0);
    run_xfer(5'd20, 5'd31, 6'd2, 1'b0);
    run_xfer(5'd5, 5'd9, 6'd0, 1'b0);

    // Overlapping copy with dst one ahead of src.
    poke(5'd0, 32'd3);
    poke(5'd1, 32'd3);
    poke(5'd2, 32'd0);
    run_xfer(5'd0, 5'd1, 6'd2, 1'b0);

    // start held high with a second pulse mid-transfer; no extra transfer afterwards.
    poke(5'd4, 32'h1111_0004);
    poke(5'd5, 32'h2222_0005);
    poke(5'd6, 32'h3333_0006);
    run_xfer(5'd4, 5'd12, 6'd3, 1'b1);
    dc0 = done_cnt;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("idle_after_hold", 32'(busy), 32'd0);
    end
    check("no_extra_done", 32'(done_cnt - dc0), 32'd0);

    // Reset during the write of word 1 of a 4-word copy.
    poke(5'd1, 32'hcafe_0001);
    exp_rd.push_back(5'd0);
    exp_rd.push_back(5'd1);
    exp_wr.push_back('{a: 5'd16, d: ref_mem[0]});
    ref_mem[16] = ref_mem[0];
    start = 1'b1;
    src   = 5'd0;
    dst   = 5'd16;
    len   = 6'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet("abort");
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_rd_q", 32'(exp_rd.size()), 32'd0);
    check("abort_wr_q", 32'(exp_wr.size()), 32'd0);
    check("abort_w17", mem[17], ref_mem[17]);
    check("abort_w18", mem[18], ref_mem[18]);

    // Normal operation after the abort, then a full-depth self copy.
    run_xfer(5'd3, 5'd28, 6'd2, 1'b0);
    run_xfer(5'd7, 5'd7, 6'd32, 1'b0);

    for (int i = 0; i < 32; i++) begin
      check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
